pc_fetch_unit: RTL and testbench

//  Program counter and instruction-fetch stage directly upstream of the controller.
//  - Holds the 8-bit PC and updates it from the controller's PC_control nibble.
//  - Fetches from a synchronous program ROM into the instruction register.
//  - The controller decodes IR[7:4]; the low nibble of PC is driven onto the data bus on PC_out.

---
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: holds the PC, applies the controller's
// PC_control requests, and fetches from a synchronous ROM into the instruction register.
module pc_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         ROM_LAT  = 1,      // legal 1..7
    parameter logic [7:0] IR_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] PC_control,
    input  logic       IR_enable,
    input  logic       PC_out,
    input  logic [3:0] bus_in,
    input  logic [7:0] rom_data,
    output logic [7:0] rom_addr,
    output logic       rom_en,
    output logic [7:0] IR,
    output logic [3:0] pc_bus,
    output logic       pc_bus_oe,
    output logic       fetch_busy,
    output logic       illegal_ctl
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PARK} state_t;

    localparam logic [2:0] CNT_INIT = 3'(ROM_LAT - 1);

    state_t     state, state_next;
    logic [7:0] pc, pc_next;
    logic [3:0] hi_stage;
    logic [7:0] park;
    logic [2:0] cnt, cnt_next;
    logic       pc_write, hi_write, illegal;
    logic       ir_load, ir_from_park, park_load;

    // Bit 0 (stage high nibble) outranks bit 1 (load), which outranks bit 3 (increment).
    always_comb begin
        pc_next  = pc;
        pc_write = 1'b0;
        hi_write = 1'b0;
        illegal  = 1'b0;
        if (PC_control[0]) begin
            hi_write = 1'b1;
            illegal  = PC_control[1];
        end else if (PC_control[1]) begin
            pc_write = 1'b1;
            pc_next  = PC_control[2] ? {pc[7:4], bus_in} : {hi_stage, bus_in};
        end else if (PC_control[3]) begin
            pc_write = 1'b1;
            pc_next  = pc + 8'd1;
        end
    end

    // Any PC write restarts the fetch, dropping whatever was in flight or parked.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ir_load      = 1'b0;
        ir_from_park = 1'b0;
        park_load    = 1'b0;
        if (pc_write) begin
            state_next = S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    state_next = S_WAIT;
                    cnt_next   = CNT_INIT;
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        if (IR_enable) begin
                            ir_load    = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            park_load  = 1'b1;
                            state_next = S_PARK;
                        end
                    end else begin
                        cnt_next = cnt - 3'd1;
                    end
                end
                S_PARK: begin
                    if (IR_enable) begin
                        ir_load      = 1'b1;
                        ir_from_park = 1'b1;
                        state_next   = S_IDLE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            hi_stage    <= 4'h0;
            park        <= 8'h00;
            IR          <= IR_RESET;
            illegal_ctl <= 1'b0;
        end else begin
            illegal_ctl <= illegal;
            if (pc_write)  pc       <= pc_next;
            if (hi_write)  hi_stage <= bus_in;
            if (park_load) park     <= rom_data;
            if (ir_load)   IR       <= ir_from_park ? park : rom_data;
        end
    end

    // Reset leaves the FSM in S_REQ; the strobe is held off until reset releases.
    assign rom_en     = (state == S_REQ) && rst_n;
    assign rom_addr   = pc;
    assign fetch_busy = (state != S_IDLE);
    assign pc_bus     = PC_out ? pc[3:0] : 4'h0;
    assign pc_bus_oe  = PC_out;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, abort/reset sequences, then random
// PC_control traffic checked against a transaction-level model of PC and fetch.
module tb_pc_fetch_unit;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] PC_control;
    logic       IR_enable;
    logic       PC_out;
    logic [3:0] bus_in;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] rom_addr;
    logic       rom_en;
    logic [7:0] IR;
    logic [3:0] pc_bus;
    logic       pc_bus_oe;
    logic       fetch_busy;
    logic       illegal_ctl;

    logic [7:0] rom_mem [256];
    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.RESET_PC(8'h00), .ROM_LAT(LAT), .IR_RESET(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .PC_control(PC_control), .IR_enable(IR_enable),
        .PC_out(PC_out), .bus_in(bus_in), .rom_data(rom_data), .rom_addr(rom_addr),
        .rom_en(rom_en), .IR(IR), .pc_bus(pc_bus), .pc_bus_oe(pc_bus_oe),
        .fetch_busy(fetch_busy), .illegal_ctl(illegal_ctl)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous ROM that only reads when strobed.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    typedef struct {
        logic [3:0] ctl;
        logic [3:0] bus;
        logic       ir_en;
        logic [7:0] pc;
        logic [7:0] ir;
        logic       busy;
        logic       ren;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] ctl, logic [3:0] bus, logic ir_en, logic [7:0] pc,
                                logic [7:0] ir, logic busy, logic ren, logic ill);
        vec_t v;
        v.ctl = ctl; v.bus = bus; v.ir_en = ir_en; v.pc = pc;
        v.ir = ir; v.busy = busy; v.ren = ren; v.ill = ill;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] pc, input logic [7:0] ir,
                            input logic busy, input logic ren, input logic ill);
        checkOutput({tag, ".pc"}, rom_addr, pc);
        checkOutput({tag, ".ir"}, IR, ir);
        checkOutput({tag, ".busy"}, {7'd0, fetch_busy}, {7'd0, busy});
        checkOutput({tag, ".rom_en"}, {7'd0, rom_en}, {7'd0, ren});
        checkOutput({tag, ".illegal"}, {7'd0, illegal_ctl}, {7'd0, ill});
        checkOutput({tag, ".pc_bus"}, {4'd0, pc_bus}, {4'd0, (PC_out ? pc[3:0] : 4'h0)});
        checkOutput({tag, ".pc_bus_oe"}, {7'd0, pc_bus_oe}, {7'd0, PC_out});
    endtask

    task automatic applyStimulus(input logic [3:0] ctl, input logic [3:0] bus,
                                 input logic ir_en, input logic pc_o);
        PC_control = ctl;
        bus_in     = bus;
        IR_enable  = ir_en;
        PC_out     = pc_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: PC/IR plus "edges until the fetched word is due" and a parked word.
    logic [7:0] m_pc, m_ir, m_park;
    logic [3:0] m_hi;
    logic       m_ill, m_parked;
    int         m_due;

    task automatic modelReset();
        m_pc = 8'h00; m_ir = 8'h00; m_hi = 4'h0; m_ill = 1'b0;
        m_parked = 1'b0; m_park = 8'h00; m_due = 1 + LAT;
    endtask

    task automatic modelStep(input logic [3:0] ctl, input logic [3:0] bus, input logic ir_en);
        bit changed = 0;
        m_ill = ctl[0] & ctl[1];
        if (ctl[0]) m_hi = bus;
        else if (ctl[1]) begin
            m_pc = ctl[2] ? {m_pc[7:4], bus} : {m_hi, bus};
            changed = 1;
        end else if (ctl[3]) begin
            m_pc = m_pc + 8'd1;
            changed = 1;
        end
        if (changed) begin
            m_due = 1 + LAT;
            m_parked = 1'b0;
        end else if (m_parked) begin
            if (ir_en) begin m_ir = m_park; m_parked = 1'b0; end
        end else if (m_due > 0) begin
            m_due--;
            if (m_due == 0) begin
                if (ir_en) m_ir = rom_mem[m_pc];
                else begin m_park = rom_mem[m_pc]; m_parked = 1'b1; end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom_mem[a] = 8'(a) ^ 8'h5A;
        rom_mem[8'h00] = 8'hC5;
        rom_mem[8'h10] = 8'h9B;

        rst_n = 1'b0; PC_control = 4'h0; bus_in = 4'h0; IR_enable = 1'b1; PC_out = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAll("reset", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkAll("release", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

        // reset fetch, wrap, JMP, carry jump, illegal code, IR hold, priority corners
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h00, 8'h00, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h00, 8'hC5, 0, 0, 0));
        vecs.push_back(mk(4'h1, 4'hF, 1, 8'h00, 8'hC5, 0, 0, 0));
        vecs.push_back(mk(4'h2, 4'hF, 1, 8'hFF, 8'hC5, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'hFF, 8'hC5, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'hFF, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(4'h8, 4'h0, 1, 8'h00, 8'hA5, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h00, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h00, 8'hC5, 0, 0, 0));
        vecs.push_back(mk(4'h1, 4'hA, 1, 8'h00, 8'hC5, 0, 0, 0));
        vecs.push_back(mk(4'h2, 4'h3, 1, 8'hA3, 8'hC5, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'hA3, 8'hC5, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'hA3, 8'hF9, 0, 0, 0));
        vecs.push_back(mk(4'h1, 4'h5, 1, 8'hA3, 8'hF9, 0, 0, 0));
        vecs.push_back(mk(4'h2, 4'h7, 1, 8'h57, 8'hF9, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h57, 8'hF9, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h57, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(4'h6, 4'h2, 1, 8'h52, 8'h0D, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h52, 8'h0D, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h52, 8'h08, 0, 0, 0));
        vecs.push_back(mk(4'h3, 4'h9, 1, 8'h52, 8'h08, 0, 0, 1));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h52, 8'h08, 0, 0, 0));
        vecs.push_back(mk(4'h2, 4'h1, 1, 8'h91, 8'h08, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h91, 8'h08, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h91, 8'hCB, 0, 0, 0));
        vecs.push_back(mk(4'h1, 4'h1, 1, 8'h91, 8'hCB, 0, 0, 0));
        vecs.push_back(mk(4'h2, 4'h0, 0, 8'h10, 8'hCB, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 0, 8'h10, 8'hCB, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 0, 8'h10, 8'hCB, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 0, 8'h10, 8'hCB, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'h10, 8'h9B, 0, 0, 0));
        vecs.push_back(mk(4'h4, 4'h7, 1, 8'h10, 8'h9B, 0, 0, 0));
        vecs.push_back(mk(4'hB, 4'hB, 1, 8'h10, 8'h9B, 0, 0, 1));
        vecs.push_back(mk(4'hA, 4'h4, 1, 8'hB4, 8'h9B, 1, 1, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'hB4, 8'h9B, 1, 0, 0));
        vecs.push_back(mk(4'h0, 4'h0, 1, 8'hB4, 8'hEE, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ctl, vecs[i].bus, vecs[i].ir_en, 1'((i % 3) == 0));
            checkAll($sformatf("row%0d", i), vecs[i].pc, vecs[i].ir, vecs[i].busy,
                     vecs[i].ren, vecs[i].ill);
        end

        // Abort: a second increment during S_WAIT must keep ROM[B5] out of IR.
        applyStimulus(4'h8, 4'h0, 1, 0);
        checkAll("abort0", 8'hB5, 8'hEE, 1, 1, 0);
        applyStimulus(4'h0, 4'h0, 1, 0);
        checkAll("abort1", 8'hB5, 8'hEE, 1, 0, 0);
        applyStimulus(4'h8, 4'h0, 1, 0);
        checkAll("abort2", 8'hB6, 8'hEE, 1, 1, 0);
        applyStimulus(4'h0, 4'h0, 1, 0);
        checkAll("abort3", 8'hB6, 8'hEE, 1, 0, 0);
        applyStimulus(4'h0, 4'h0, 1, 0);
        checkAll("abort4", 8'hB6, 8'hEC, 0, 0, 0);

        // Async reset in the middle of S_WAIT takes effect without a clock edge.
        applyStimulus(4'h8, 4'h0, 1, 0);
        applyStimulus(4'h0, 4'h0, 1, 0);
        checkAll("prereset", 8'hB7, 8'hEC, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkAll("asyncrst", 8'h00, 8'h00, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        modelReset();
        checkAll("rerelease", m_pc, m_ir, 1, 1, 0);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] ctl, bus;
            logic       ir_en, pc_o;
            ctl   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus   = 4'($urandom_range(0, 15));
            ir_en = ($urandom_range(0, 9) < 7);
            pc_o  = 1'($urandom_range(0, 1));
            applyStimulus(ctl, bus, ir_en, pc_o);
            modelStep(ctl, bus, ir_en);
            checkAll($sformatf("rand%0d", n), m_pc, m_ir, (m_due > 0) || m_parked,
                     (m_due == 1 + LAT), m_ill);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
